// File: rtl/apb_tx_regbank.sv
// apb_tx_regbank: per-channel APB register bank with a shared transmit queue (valid/ready out).
// Define APB_TX_IRQ_EN to enable per-channel status-change flags and irq_tx_o.
module apb_tx_regbank #(
   parameter int unsigned CH_BITS    = 1,
   parameter int unsigned DATAWIDTH  = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          PCLK_tx,
   input  logic                          PRESET_tx,
   input  logic [CH_BITS+2:0]            PADDR_tx_i,
   input  logic [DATAWIDTH-1:0]          PWDATA_tx_i,
   input  logic                          PWRITE_tx_i,
   input  logic                          PSELx_tx_i,
   input  logic                          PENABLE_tx_i,
   output logic [DATAWIDTH-1:0]          PRDATA_tx_o,
   output logic                          PREADY_tx_o,
   output logic                          PSLVERR_tx_o,
   output logic [(2**CH_BITS)*8-1:0]     prescale_tx,
   output logic [(2**CH_BITS)*8-1:0]     reg_command_tx,
   output logic [(2**CH_BITS)*8-1:0]     reg_id_tx,
   output logic [(2**CH_BITS)*16-1:0]    reg_data_field_tx,
   input  logic [(2**CH_BITS)*8-1:0]     reg_status_tx,
   output logic                          tx_valid_o,
   input  logic                          tx_ready_i,
   output logic [CH_BITS-1:0]            tx_ch_o,
   output logic [11:0]                   tx_word_o,
   output logic                          irq_tx_o
);

   localparam int unsigned NUM_CH       = 2 ** CH_BITS;
   localparam int unsigned ADDRESSWIDTH = CH_BITS + 3;
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENTRY_W      = CH_BITS + 12;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e               r_state;
   state_e               w_phase;

   logic [7:0]           r_prescale   [NUM_CH];
   logic [7:0]           r_command    [NUM_CH];
   logic [7:0]           r_id         [NUM_CH];
   logic [15:0]          r_data_field [NUM_CH];
   logic [11:0]          r_last       [NUM_CH];
   logic [7:0]           w_status     [NUM_CH];

   logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wptr;
   logic [PTR_W-1:0]     r_rptr;
   logic [CNT_W-1:0]     r_count;

   logic [CH_BITS-1:0]   w_ch;
   logic [2:0]           w_off;
   logic                 w_full;
   logic                 w_stall;
   logic                 w_commit;
   logic                 w_err;
   logic                 w_wr;
   logic                 w_push;
   logic                 w_pop;
   logic [DATAWIDTH-1:0] w_rdata;
   logic                 w_unused_bits;

   assign w_ch          = PADDR_tx_i[ADDRESSWIDTH-1:3];
   assign w_off         = PADDR_tx_i[2:0];
   assign w_unused_bits = ^PWDATA_tx_i[DATAWIDTH-1:16];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign prescale_tx[8*g +: 8]         = r_prescale[g];
      assign reg_command_tx[8*g +: 8]      = r_command[g];
      assign reg_id_tx[8*g +: 8]           = r_id[g];
      assign reg_data_field_tx[16*g +: 16] = r_data_field[g];
      assign w_status[g]                   = reg_status_tx[8*g +: 8];
   end

   // Current bus phase: ACCESS only when a SETUP (or a stalled ACCESS) preceded it;
   // PENABLE straight out of IDLE is treated as a protocol violation and ignored.
   always_comb begin
      w_phase = StIdle;
      if (PSELx_tx_i) begin
         if (!PENABLE_tx_i) begin
            w_phase = StSetup;
         end else if (r_state != StIdle) begin
            w_phase = StAccess;
         end
      end
   end

   // Full uses the registered count only, so a same-cycle pop does not release the stall.
   assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_stall  = (w_phase == StAccess) && PWRITE_tx_i && (w_off == 3'd2) && w_full;
   assign w_commit = (w_phase == StAccess) && !w_stall;

   always_comb begin
      w_err = 1'b0;
      case (w_off)
         3'd2:       w_err = PWRITE_tx_i && w_status[w_ch][7];
         3'd5, 3'd7: w_err = PWRITE_tx_i;
`ifdef APB_TX_IRQ_EN
         3'd6:       w_err = 1'b0;
`else
         3'd6:       w_err = 1'b1;
`endif
         default:    w_err = 1'b0;
      endcase
   end

   assign w_wr   = w_commit && PWRITE_tx_i && !w_err;
   assign w_push = w_wr && (w_off == 3'd2);
   assign w_pop  = (r_count != '0) && tx_ready_i;

   assign PREADY_tx_o  = !w_stall;
   assign PSLVERR_tx_o = w_commit && w_err;

`ifdef APB_TX_IRQ_EN
   logic [7:0] r_flags       [NUM_CH];
   logic [7:0] r_status_prev [NUM_CH];
   logic [7:0] w_flags_next  [NUM_CH];
   logic       w_flags_any;
   logic       r_irq;

   // A rising status bit sets its flag even when software clears the same bit this cycle.
   always_comb begin
      w_flags_any = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_flags_next[c] = (r_flags[c] &
                            ~((w_wr && (w_off == 3'd6) && (w_ch == CH_BITS'(c))) ?
                              PWDATA_tx_i[7:0] : 8'h00)) |
                           (w_status[c] & ~r_status_prev[c]);
         w_flags_any     = w_flags_any | (|w_flags_next[c]);
      end
   end

   always_ff @(posedge PCLK_tx) begin
      for (int c = 0; c < NUM_CH; c++) begin
         r_status_prev[c] <= w_status[c];
      end
      if (PRESET_tx) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_flags[c] <= '0;
         end
         r_irq <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_flags[c] <= w_flags_next[c];
         end
         r_irq <= w_flags_any;
      end
   end

   assign irq_tx_o = r_irq;
`else
   assign irq_tx_o = 1'b0;
`endif

   always_comb begin
      w_rdata = '0;
      case (w_off)
         3'd0: w_rdata[7:0]       = r_prescale[w_ch];
         3'd1: w_rdata[7:0]       = r_command[w_ch];
         3'd2: w_rdata[11:0]      = r_last[w_ch];
         3'd3: w_rdata[7:0]       = r_id[w_ch];
         3'd4: w_rdata[15:0]      = r_data_field[w_ch];
         3'd5: w_rdata[7:0]       = w_status[w_ch];
`ifdef APB_TX_IRQ_EN
         3'd6: w_rdata[7:0]       = r_flags[w_ch];
`else
         3'd6: w_rdata            = '0;
`endif
         default: w_rdata[CNT_W-1:0] = r_count;
      endcase
   end

   assign PRDATA_tx_o = (w_commit && !PWRITE_tx_i && !w_err) ? w_rdata : '0;

   always_ff @(posedge PCLK_tx) begin
      if (PRESET_tx) begin
         r_state <= StIdle;
      end else begin
         case (w_phase)
            StAccess: r_state <= w_stall ? StAccess : StIdle;
            StSetup:  r_state <= StSetup;
            default:  r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge PCLK_tx) begin
      if (PRESET_tx) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_prescale[c]   <= '0;
            r_command[c]    <= '0;
            r_id[c]         <= '0;
            r_data_field[c] <= '0;
            r_last[c]       <= '0;
         end
      end else if (w_wr) begin
         case (w_off)
            3'd0:    r_prescale[w_ch]   <= PWDATA_tx_i[7:0];
            3'd1:    r_command[w_ch]    <= PWDATA_tx_i[7:0];
            3'd2:    r_last[w_ch]       <= PWDATA_tx_i[11:0];
            3'd3:    r_id[w_ch]         <= PWDATA_tx_i[7:0];
            3'd4:    r_data_field[w_ch] <= PWDATA_tx_i[15:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge PCLK_tx) begin
      if (PRESET_tx) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= {w_ch, PWDATA_tx_i[11:0]};
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign tx_valid_o = (r_count != '0);
   assign {tx_ch_o, tx_word_o} = r_mem[r_rptr];

endmodule

// File: tb/tb_apb_tx_regbank.sv
// Directed bench for apb_tx_regbank: scoreboard queues for APB completions and tx hand-offs.
module tb_apb_tx_regbank;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic        pwrite, psel, penable;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [15:0] prescale, command, id, status;
   logic [31:0] data_field;
   logic        tx_valid, tx_ready, tx_ch, irq;
   logic [11:0] tx_word;

   int total = 0;
   int bad   = 0;
   int apb_seq = 0;

   typedef struct {
      int          seq;
      logic [31:0] rd;
      logic        err;
   } apb_exp_t;

   apb_exp_t    apbq[$];
   logic [12:0] txq[$];

   always #5 clk = ~clk;

   apb_tx_regbank #(
      .CH_BITS   (1),
      .DATAWIDTH (32),
      .FIFO_DEPTH(4)
   ) dut (
      .PCLK_tx          (clk),
      .PRESET_tx        (rst),
      .PADDR_tx_i       (paddr),
      .PWDATA_tx_i      (pwdata),
      .PWRITE_tx_i      (pwrite),
      .PSELx_tx_i       (psel),
      .PENABLE_tx_i     (penable),
      .PRDATA_tx_o      (prdata),
      .PREADY_tx_o      (pready),
      .PSLVERR_tx_o     (pslverr),
      .prescale_tx      (prescale),
      .reg_command_tx   (command),
      .reg_id_tx        (id),
      .reg_data_field_tx(data_field),
      .reg_status_tx    (status),
      .tx_valid_o       (tx_valid),
      .tx_ready_i       (tx_ready),
      .tx_ch_o          (tx_ch),
      .tx_word_o        (tx_word),
      .irq_tx_o         (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT completes a transfer or hands off a word.
   always @(negedge clk) begin
      if (psel && penable && pready) begin
         if (apbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL apb_unexpected: got completion expected none");
         end else begin
            apb_exp_t e;
            e = apbq.pop_front();
            check($sformatf("apb%0d_rdata", e.seq), prdata, e.rd);
            check($sformatf("apb%0d_slverr", e.seq), {31'b0, pslverr}, {31'b0, e.err});
         end
      end
      if (tx_valid && tx_ready) begin
         if (txq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got word 0x%0h expected none", tx_word);
         end else begin
            logic [12:0] w;
            w = txq.pop_front();
            check("tx_pop", {19'b0, tx_ch, tx_word}, {19'b0, w});
         end
      end
   end

   task automatic apb(input logic wr, input logic ch, input logic [2:0] off,
                      input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
      int n;
      apb_exp_t e;
      e.seq = apb_seq;
      e.rd  = exp_rd;
      e.err = exp_err;
      apb_seq++;
      apbq.push_back(e);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {ch, off}; pwdata = data;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pready && n < 20);
      if (!pready) begin
         total++;
         bad++;
         $display("FAIL apb%0d_timeout: got pready=0 expected completion", e.seq);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic txw(input logic ch, input logic [11:0] word);
      txq.push_back({ch, word});
      apb(1'b1, ch, 3'd2, {20'h0, word}, 32'h0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      status = '0; tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_pready", {31'b0, pready}, 32'd1);
      check("rst_pslverr", {31'b0, pslverr}, 32'd0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_id", {16'b0, id}, 32'd0);

      // Basic register write / readback
      apb(1, 1, 3'd3, 32'h5A, 32'h0, 0);
      apb(0, 1, 3'd3, 32'h0, 32'h5A, 0);
      check("id_out", {16'b0, id}, 32'h5A00);
      apb(1, 0, 3'd0, 32'h1234, 32'h0, 0);
      apb(0, 0, 3'd0, 32'h0, 32'h34, 0);
      apb(1, 1, 3'd4, 32'hFFFF_BEEF, 32'h0, 0);
      apb(0, 1, 3'd4, 32'h0, 32'hBEEF, 0);
      check("data_field_out", data_field, 32'hBEEF_0000);
      apb(1, 0, 3'd1, 32'hC3, 32'h0, 0);
      check("command_out", {16'b0, command}, 32'h00C3);

      // Status read and read-only error
      status = 16'h0012;
      apb(0, 0, 3'd5, 32'h0, 32'h12, 0);
      apb(1, 0, 3'd5, 32'hFF, 32'h0, 1);
      apb(0, 0, 3'd5, 32'h0, 32'h12, 0);
      check("ro_prescale", {16'b0, prescale}, 32'h0034);
      check("ro_id", {16'b0, id}, 32'h5A00);

      // Transmit write while channel busy
      status = 16'h0080;
      apb(1, 0, 3'd2, 32'hABC, 32'h0, 1);
      check("busy_no_valid", {31'b0, tx_valid}, 32'd0);
      apb(0, 0, 3'd7, 32'h0, 32'h0, 0);
      apb(0, 0, 3'd2, 32'h0, 32'h0, 0);
      status = 16'h0000;

      // Pushes, count, last-word readback
      txw(0, 12'h111);
      txw(1, 12'h222);
      check("head_valid", {31'b0, tx_valid}, 32'd1);
      check("head_word", {19'b0, tx_ch, tx_word}, {19'b0, 1'b0, 12'h111});
      apb(0, 0, 3'd7, 32'h0, 32'h2, 0);
      apb(1, 1, 3'd7, 32'h5, 32'h0, 1);
      apb(0, 1, 3'd2, 32'h0, 32'h222, 0);

      // Fill to full, fifth write stalls until one pop
      txw(0, 12'h333);
      txw(0, 12'h444);
      fork
         txw(0, 12'h555);
         begin
            repeat (4) @(posedge clk);
            #1;
            check("stall_pready", {31'b0, pready}, 32'd0);
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
         end
      join
      apb(0, 0, 3'd7, 32'h0, 32'h4, 0);

      // Drain the queue
      tx_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 tx_ready = 1'b0;
      check("drained", {31'b0, tx_valid}, 32'd0);

`ifdef APB_TX_IRQ_EN
      apb(0, 0, 3'd6, 32'h0, 32'h92, 0);
      apb(1, 0, 3'd6, 32'hFF, 32'h0, 0);
      check("irq_cleared", {31'b0, irq}, 32'd0);
      status = 16'h0100;
      @(posedge clk); #1;
      check("irq_set", {31'b0, irq}, 32'd1);
      apb(0, 1, 3'd6, 32'h0, 32'h01, 0);
      apb(1, 1, 3'd6, 32'h01, 32'h0, 0);
      check("irq_w1c", {31'b0, irq}, 32'd0);
      apb(0, 1, 3'd6, 32'h0, 32'h0, 0);
      status = 16'h0000;
`else
      status = 16'h0100;
      @(posedge clk); #1;
      check("irq_tied", {31'b0, irq}, 32'd0);
      apb(0, 0, 3'd6, 32'h0, 32'h0, 1);
      apb(1, 1, 3'd6, 32'h01, 32'h0, 1);
      status = 16'h0000;
`endif

      // Reset in the middle of a stalled transmit write
      txw(1, 12'h601);
      txw(1, 12'h602);
      txw(1, 12'h603);
      txw(1, 12'h604);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {1'b0, 3'd2}; pwdata = 32'h777;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      check("rst_stall_pready", {31'b0, pready}, 32'd0);
      rst = 1'b1;
      txq.delete();
      @(posedge clk); #1;
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      check("post_rst_pready", {31'b0, pready}, 32'd1);
      check("post_rst_valid", {31'b0, tx_valid}, 32'd0);
      check("post_rst_word", {19'b0, tx_ch, tx_word}, 32'd0);
      check("post_rst_regs", {prescale, id}, 32'd0);
      check("post_rst_cmd_df", {command, data_field[31:16]}, 32'd0);
      check("post_rst_irq", {31'b0, irq}, 32'd0);
      apb(0, 0, 3'd7, 32'h0, 32'h0, 0);
      apb(0, 1, 3'd2, 32'h0, 32'h0, 0);

      // PENABLE without a preceding setup phase is ignored
      begin
         apb_exp_t e;
         e.seq = apb_seq; e.rd = 32'h0; e.err = 1'b0;
         apb_seq++;
         apbq.push_back(e);
      end
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = {1'b0, 3'd0}; pwdata = 32'h77;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      check("violation_no_write", {16'b0, prescale}, 32'd0);

      repeat (2) @(posedge clk);
      #1;
      check("apbq_empty", apbq.size(), 32'd0);
      check("txq_empty", txq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_tx_regbank.md
# apb_tx_regbank

Multi-channel APB register bank for the frame transmitters: holds per-channel prescale, command, ID and data-field registers, and queues transmit words toward the transmitter datapath through a shared FIFO with valid/ready hand-off. It sits between the APB interconnect and NUM_CH transmitter engines. Unlike the single-channel bank, it inserts wait states on queue full, reports errors via PSLVERR, tracks APB phase with an FSM, and optionally raises a status-change interrupt.

## Interface
- CH_BITS, 1: channel index width; NUM_CH = 2**CH_BITS (localparam).
- DATAWIDTH, 32: APB data width, ≥16.
- FIFO_DEPTH, 4: transmit-queue entries, power of two, ≥2.
- ADDRESSWIDTH: localparam = CH_BITS+3; PADDR = {channel, offset[2:0]}.

- PCLK_tx  in  1  sole clock, rising edge.
- PRESET_tx  in  1  synchronous, active-high reset.
- PADDR_tx_i  in  ADDRESSWIDTH  address.
- PWDATA_tx_i  in  DATAWIDTH  write data.
- PWRITE_tx_i, PSELx_tx_i, PENABLE_tx_i  in  1 each  APB controls.
- PRDATA_tx_o  out  DATAWIDTH  read data, combinational, valid when PREADY high in ACCESS, else 0.
- PREADY_tx_o  out  1  transfer completion.
- PSLVERR_tx_o  out  1  error, qualified by PREADY in ACCESS.
- prescale_tx, reg_command_tx, reg_id_tx  out  NUM_CH*8  per-channel registers, channel c at [8c+7:8c].
- reg_data_field_tx  out  NUM_CH*16  per-channel data field.
- reg_status_tx  in  NUM_CH*8  per-channel status; bit 7 = busy.
- tx_valid_o  out  1  queue head valid.
- tx_ready_i  in  1  transmitter accepts head.
- tx_ch_o  out  CH_BITS  head channel.
- tx_word_o  out  12  head transmit word.
- irq_tx_o  out  1  interrupt (0 without macro).

## Operation
- Offsets: 0 prescale[7:0] RW; 1 command[7:0] RW; 2 transmit: write pushes {ch, PWDATA[11:0]}, read returns last pushed word of that channel; 3 id[7:0] RW; 4 data_field[15:0] RW; 5 status RO; 6 irq flags W1C (macro); 7 queue count RO. Read data zero-extended.
- FSM states IDLE, SETUP, ACCESS. IDLE→SETUP on PSEL&!PENABLE; SETUP→ACCESS on PSEL&PENABLE; ACCESS→IDLE (or SETUP if PSEL&!PENABLE) when PREADY high; PSEL low anywhere → IDLE. PENABLE seen in IDLE is a protocol violation: ignored, no write, PREADY high, PSLVERR 0.
- Register update occurs only on the single cycle state==ACCESS & PREADY.
- PSLVERR=1 (no state change) for: write to 5 or 7; any access to 6 without macro; transmit write while that channel's status[7]=1.
- Queue: count 0..FIFO_DEPTH. Pop when tx_valid_o & tx_ready_i. Push and pop same cycle: count unchanged. Full uses registered count only (pop on same cycle does not release stall).

## Timing
- Reset: all registers, FIFO pointers/count, last-pushed words, irq flags 0; FSM IDLE; PREADY_tx_o 1; PSLVERR_tx_o 0; PRDATA_tx_o 0; tx_valid_o 0; irq_tx_o 0.
- Zero wait states except transmit write in ACCESS with queue full: PREADY low until count<FIFO_DEPTH, completes that cycle.
- Busy check for transmit write is evaluated on the completing cycle.
- Pushed word visible on tx_*_o the cycle after push if queue was empty.
- Reset during stalled write: transfer discarded, no push.

## Configuration
- APB_TX_IRQ_EN defined: per-channel 8-bit flags set on rising edge of each status bit (edge register loaded with status during reset, so no flag at reset release); offset 6 reads flags, write-1 clears; set wins over simultaneous clear; irq_tx_o = registered OR of all flags, one cycle after set.
- Undefined: no flag logic, offset 6 errors, irq_tx_o tied 0.

## Test plan
- Write ch1 offset 3 = 0x5A, read back -> PRDATA 0x5A, PSLVERR 0, reg_id_tx[15:8]=0x5A, ch0 unchanged.
- tx_ready_i=0, five transmit writes ch0 (FIFO_DEPTH 4) -> 4 complete, 5th PREADY low; raise tx_ready_i one cycle -> 5th completes next cycle, count 4.
- reg_status_tx[7]=1, transmit write 0xABC ch0 -> PSLVERR 1, count unchanged, no tx_valid_o.
- Write offset 5 with 0xFF -> PSLVERR 1, registers unchanged; read offset 7 after 2 pushes -> 2.
- With APB_TX_IRQ_EN: status ch1 bit0 0→1 -> irq_tx_o 1 next cycle; write 0x01 to ch1 offset 6 -> flag and irq clear.
- Assert PRESET_tx mid-stall -> PREADY 1, queue empty, all outputs zero next cycle.
